// File: rtl/vm_pkg.sv
// Shared coin encodings, coin unit values and controller states for the multi-product vending machine.
package vm_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  localparam logic [2:0] UNITS_5   = 3'd1;
  localparam logic [2:0] UNITS_10  = 3'd2;
  localparam logic [2:0] UNITS_20  = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } vm_state_e;

  function automatic logic [2:0] coin_units(input logic [1:0] coin);
    case (coin)
      COIN_5:  return UNITS_5;
      COIN_10: return UNITS_10;
      COIN_20: return UNITS_20;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vending_machine_multi_if.sv
// Coin-acceptor / selector / hopper bundle; the master drives requests, the slave is the controller.
interface vending_machine_multi_if #(
  parameter int ITEM_W    = 2,
  parameter int CREDIT_W  = 6,
  parameter int NUM_ITEMS = 4
);
  logic [1:0]           coin;
  logic                 sel_valid;
  logic [ITEM_W-1:0]    sel;
  logic                 cancel;
  logic                 change_ready;
  logic                 restock;
  logic                 vend_valid;
  logic [ITEM_W-1:0]    vend_item;
  logic                 coin_reject;
  logic                 sel_reject;
  logic                 change_valid;
  logic [1:0]           change_coin;
  logic [CREDIT_W-1:0]  credit;
  logic [NUM_ITEMS-1:0] sold_out;

  modport master (
    output coin, sel_valid, sel, cancel, change_ready, restock,
    input  vend_valid, vend_item, coin_reject, sel_reject,
           change_valid, change_coin, credit, sold_out
  );

  modport slave (
    input  coin, sel_valid, sel, cancel, change_ready, restock,
    output vend_valid, vend_item, coin_reject, sel_reject,
           change_valid, change_coin, credit, sold_out
  );
endinterface

// File: rtl/vm_change_dispenser.sv
// Greedy change emitter: loads a remainder and offers the largest fitting coin over a valid/ready handshake.
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [CREDIT_W-1:0] amount_i,
  input  logic                change_ready_i,
  output logic                change_valid_o,
  output logic [1:0]          change_coin_o,
  output logic                done_o
);

  logic [CREDIT_W-1:0] remain_q, remain_d, left_s;
  logic                valid_q, valid_d;
  logic [1:0]          coin_q, coin_d;

  function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] r);
    if (r >= CREDIT_W'(UNITS_20)) begin
      return COIN_20;
    end else if (r >= CREDIT_W'(UNITS_10)) begin
      return COIN_10;
    end else begin
      return COIN_5;
    end
  endfunction

  // Next remainder and offered coin; a new load is only taken while idle.
  always_comb begin
    remain_d = remain_q;
    valid_d  = valid_q;
    coin_d   = coin_q;
    left_s   = remain_q - CREDIT_W'(coin_units(coin_q));
    if (valid_q) begin
      if (change_ready_i) begin
        remain_d = left_s;
        if (left_s == '0) begin
          valid_d = 1'b0;
          coin_d  = COIN_NONE;
        end else begin
          coin_d  = greedy_coin(left_s);
        end
      end else begin
        remain_d = remain_q;
      end
    end else if (load_i && (amount_i != '0)) begin
      remain_d = amount_i;
      valid_d  = 1'b1;
      coin_d   = greedy_coin(amount_i);
    end else begin
      remain_d = remain_q;
    end
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      remain_q <= '0;
      valid_q  <= 1'b0;
      coin_q   <= COIN_NONE;
    end else begin
      remain_q <= remain_d;
      valid_q  <= valid_d;
      coin_q   <= coin_d;
    end
  end

  assign change_valid_o = valid_q;
  assign change_coin_o  = coin_q;
  assign done_o         = valid_q & change_ready_i & (left_s == '0);

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: credit accumulation, selection, vend pulse and change hand-off.
// Optional per-item inventory is enabled with the VM_INVENTORY_EN macro.
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int                            NUM_ITEMS  = 4,
  parameter int                            ITEM_W     = 2,
  parameter int                            CREDIT_W   = 6,
  parameter int                            MAX_CREDIT = 20,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = {6'd6, 6'd4, 6'd3, 6'd2},
  parameter int                            STOCK_INIT = 8
) (
  input logic                    clk,
  input logic                    rst,
  vending_machine_multi_if.slave bus
);

  localparam int SUM_W = CREDIT_W + 1;

  vm_state_e             state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d, price_s;
  logic                  vend_valid_q, vend_valid_d;
  logic [ITEM_W-1:0]     vend_item_q, vend_item_d;
  logic                  coin_reject_q, coin_reject_d;
  logic                  sel_reject_q, sel_reject_d;
  logic [NUM_ITEMS-1:0]  sold_out_q, sold_out_d;
  logic [SUM_W-1:0]      coin_sum_s;
  logic                  coin_present_s, coin_fits_s, sel_ok_s, in_stock_s;
  logic                  load_s, chg_valid_s, chg_done_s;
  logic [1:0]            chg_coin_s;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [ITEM_W-1:0] idx);
    logic [CREDIT_W-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (int'(idx) == i) p = PRICES[i*CREDIT_W +: CREDIT_W];
    end
    return p;
  endfunction

  // Controller next state: cancel beats selection beats coin.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    vend_valid_d   = 1'b0;
    vend_item_d    = vend_item_q;
    coin_reject_d  = 1'b0;
    sel_reject_d   = 1'b0;
    load_s         = 1'b0;
    price_s        = price_of(bus.sel);
    coin_present_s = (bus.coin != COIN_NONE);
    coin_sum_s     = SUM_W'(credit_q) + SUM_W'(coin_units(bus.coin));
    coin_fits_s    = (coin_sum_s <= SUM_W'(MAX_CREDIT));
    in_stock_s     = ~|(sold_out_q & (NUM_ITEMS'(1) << bus.sel));
    sel_ok_s       = (int'(bus.sel) < NUM_ITEMS) && in_stock_s && (credit_q >= price_s);
    case (state_q)
      IDLE, COLLECT: begin
        if (bus.cancel && (state_q == COLLECT)) begin
          state_d       = CHANGE;
          load_s        = 1'b1;
          coin_reject_d = coin_present_s;
        end else if (bus.sel_valid) begin
          coin_reject_d = coin_present_s;
          if ((state_q == COLLECT) && sel_ok_s) begin
            state_d      = VEND;
            credit_d     = credit_q - price_s;
            vend_valid_d = 1'b1;
            vend_item_d  = bus.sel;
          end else begin
            sel_reject_d = 1'b1;
          end
        end else if (bus.cancel) begin
          coin_reject_d = coin_present_s;
        end else if (coin_present_s) begin
          if (coin_fits_s) begin
            credit_d = coin_sum_s[CREDIT_W-1:0];
            state_d  = COLLECT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      VEND: begin
        coin_reject_d = coin_present_s;
        sel_reject_d  = bus.sel_valid;
        if (credit_q != '0) begin
          state_d = CHANGE;
          load_s  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        coin_reject_d = coin_present_s;
        sel_reject_d  = bus.sel_valid;
        if (chg_done_s) begin
          state_d  = IDLE;
          credit_d = '0;
        end else if (chg_valid_s && bus.change_ready) begin
          credit_d = credit_q - CREDIT_W'(coin_units(chg_coin_s));
        end else begin
          credit_d = credit_q;
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
  end

`ifdef VM_INVENTORY_EN
  localparam int STOCK_W = (STOCK_INIT < 1) ? 1 : $clog2(STOCK_INIT + 1);

  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0] stock_d [NUM_ITEMS];

  // Stock reload in IDLE, decrement on the cycle the item is dispensed.
  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      stock_d[i] = stock_q[i];
      if ((state_q == IDLE) && bus.restock) begin
        stock_d[i] = STOCK_W'(STOCK_INIT);
      end else if ((state_q == VEND) && (int'(vend_item_q) == i) && (stock_q[i] != '0)) begin
        stock_d[i] = stock_q[i] - STOCK_W'(1);
      end else begin
        stock_d[i] = stock_q[i];
      end
      sold_out_d[i] = (stock_d[i] == '0);
    end
  end

  // Stock counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (rst) begin
        stock_q[i] <= STOCK_W'(STOCK_INIT);
      end else begin
        stock_q[i] <= stock_d[i];
      end
    end
  end
`else
  logic unused_restock_s;
  assign unused_restock_s = bus.restock;
  assign sold_out_d       = '0;
`endif

  // Controller and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      vend_valid_q  <= 1'b0;
      vend_item_q   <= '0;
      coin_reject_q <= 1'b0;
      sel_reject_q  <= 1'b0;
      sold_out_q    <= '0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      vend_valid_q  <= vend_valid_d;
      vend_item_q   <= vend_item_d;
      coin_reject_q <= coin_reject_d;
      sel_reject_q  <= sel_reject_d;
      sold_out_q    <= sold_out_d;
    end
  end

  vm_change_dispenser #(.CREDIT_W(CREDIT_W)) u_change (
    .clk            (clk),
    .rst            (rst),
    .load_i         (load_s),
    .amount_i       (credit_q),
    .change_ready_i (bus.change_ready),
    .change_valid_o (chg_valid_s),
    .change_coin_o  (chg_coin_s),
    .done_o         (chg_done_s)
  );

  assign bus.vend_valid   = vend_valid_q;
  assign bus.vend_item    = vend_item_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.sel_reject   = sel_reject_q;
  assign bus.change_valid = chg_valid_s;
  assign bus.change_coin  = chg_coin_s;
  assign bus.credit       = credit_q;
  assign bus.sold_out     = sold_out_q;

endmodule
